// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the counter controller.
// Holds the controller state enum, the mode encodings and a small state
// decode helper used by the top level.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // A sequence is in progress while counting or held by pause.
    function automatic logic is_active(input ctrl_state_t state);
        return (state == ST_RUN) || (state == ST_HOLD);
    endfunction

endpackage

// File: rtl/count_core.sv
// count_core: WIDTH-bit up counter with synchronous clear, count enable and
// a terminal-match flag comparing the count against a supplied limit.
// Clear takes priority over enable; wrap is never used by the controller.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_match
);

    logic [WIDTH-1:0] r_count;

    // Count register: reset/clear to zero, otherwise increment when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_match = (r_count == i_limit);

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/pause/abort controlled step counter with one-shot and
// periodic modes. Steps advance the count up to the latched limit; the
// terminal step raises tick for one cycle and either restarts at zero
// (periodic) or finishes through a one-cycle DONE state (one-shot).
// Optional feature: define COUNTER_CTRL_PRESCALE_EN to step only once every
// PRESCALE_DIV cycles in RUN instead of on every RUN cycle.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_mode_q;
    logic             r_tick;
    logic             r_done;

    logic             w_start_acc;
    logic             w_abort_act;
    logic             w_run_go;
    logic             w_step_en;
    logic             w_terminal;
    logic             w_core_clr;
    logic             w_core_en;
    logic             w_match;
    logic [WIDTH-1:0] w_count;

    assign w_start_acc = (r_state == ST_IDLE) && start_valid;
    assign w_abort_act = abort && (r_state != ST_IDLE);
    // RUN cycle that is neither aborted nor paused: the only place a step may happen.
    assign w_run_go    = (r_state == ST_RUN) && !abort && !pause;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE_DIV);

    logic [PW-1:0] r_presc;
    logic          w_presc_last;

    assign w_presc_last = (r_presc == PW'(PRESCALE_DIV - 1));

    // Prescaler: restarts on start/abort, advances only on live RUN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_start_acc || w_abort_act) begin
            r_presc <= '0;
        end else if (w_run_go) begin
            r_presc <= w_presc_last ? '0 : (r_presc + PW'(1));
        end else begin
            r_presc <= r_presc;
        end
    end

    assign w_step_en = w_run_go && w_presc_last;
`else
    assign w_step_en = w_run_go;
`endif

    assign w_terminal = w_step_en && w_match;
    // Periodic terminal step restarts from zero; one-shot terminal step holds.
    assign w_core_clr = w_start_acc || w_abort_act ||
                        (w_terminal && (r_mode_q == MODE_PERIODIC));
    assign w_core_en  = w_step_en && !w_match;

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_core_clr),
        .i_en    (w_core_en),
        .i_limit (r_limit_q),
        .o_count (w_count),
        .o_match (w_match)
    );

    // Sequence configuration captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_limit_q <= '0;
            r_mode_q  <= MODE_ONESHOT;
        end else if (w_start_acc) begin
            r_limit_q <= limit;
            r_mode_q  <= mode;
        end else begin
            r_limit_q <= r_limit_q;
            r_mode_q  <= r_mode_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; abort outranks pause, pause outranks stepping.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (pause) begin
                    w_next_state = ST_HOLD;
                end else if (w_terminal && (r_mode_q == MODE_ONESHOT)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!pause) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Pulse registers: tick follows a terminal step, done follows an unaborted DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= w_terminal;
            r_done <= (r_state == ST_DONE) && !abort;
        end
    end

    // FSM output decode from the registered state only.
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            ST_RUN, ST_HOLD: begin
                start_ready = 1'b0;
                busy        = is_active(r_state);
            end
            ST_DONE: begin
                start_ready = 1'b0;
                busy        = 1'b0;
            end
            default: begin
                start_ready = 1'b0;
                busy        = 1'b0;
            end
        endcase
    end

    assign count = w_count;
    assign tick  = r_tick;
    assign done  = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl with a step-count based
// reference model checked every cycle plus hand-computed literal pins.
// Build with COUNTER_CTRL_PRESCALE_EN defined to exercise the prescaler.
module tb_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] limit;
    logic             mode;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tick;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    counter_ctrl #(
        .WIDTH        (WIDTH),
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .limit       (limit),
        .mode        (mode),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .tick        (tick),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: a sequence is described by how many steps it has taken.
    int m_steps, m_lim, m_pre, m_count;
    bit m_mode, m_live, m_held, m_fin, m_valid;
    bit e_tick, e_done;

    initial begin
        bit step;
        m_valid = 1'b0;
        m_live = 1'b0; m_held = 1'b0; m_fin = 1'b0;
        m_steps = 0; m_lim = 0; m_pre = 0; m_count = 0; m_mode = 1'b0;
        e_tick = 1'b0; e_done = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_count", int'(count), m_count);
                chk("m_tick", int'(tick), int'(e_tick));
                chk("m_done", int'(done), int'(e_done));
                chk("m_busy", int'(busy), int'(m_live));
                chk("m_ready", int'(start_ready), int'(!m_live && !m_fin));
            end
            // predict the effect of the coming rising edge
            e_tick = 1'b0;
            e_done = 1'b0;
            if (rst) begin
                m_live = 1'b0; m_held = 1'b0; m_fin = 1'b0;
                m_steps = 0; m_lim = 0; m_pre = 0; m_count = 0; m_mode = 1'b0;
                m_valid = 1'b1;
            end else if (m_fin) begin
                m_fin = 1'b0;
                if (abort) m_count = 0;
                else e_done = 1'b1;
            end else if (!m_live) begin
                if (start_valid) begin
                    m_live = 1'b1; m_held = 1'b0; m_steps = 0; m_pre = 0;
                    m_lim = int'(limit); m_mode = mode; m_count = 0;
                end
            end else if (abort) begin
                m_live = 1'b0; m_held = 1'b0; m_count = 0;
            end else if (m_held) begin
                if (!pause) m_held = 1'b0;
            end else if (pause) begin
                m_held = 1'b1;
            end else begin
                step = 1'b1;
`ifdef COUNTER_CTRL_PRESCALE_EN
                m_pre++;
                step = (m_pre == DIV);
                if (step) m_pre = 0;
`endif
                if (step) begin
                    m_steps++;
                    if (m_steps % (m_lim + 1) == 0) e_tick = 1'b1;
                    if (m_mode) begin
                        m_count = m_steps % (m_lim + 1);
                    end else begin
                        m_count = (m_steps > m_lim) ? m_lim : m_steps;
                        if (m_steps == m_lim + 1) begin
                            m_live = 1'b0;
                            m_fin = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int lim, input bit md);
        start_valid = 1'b1;
        limit = WIDTH'(lim);
        mode = md;
        cyc();
        start_valid = 1'b0;
    endtask

    task automatic idle_out();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
    endtask

    initial begin
        int ticks;
        int first1;
        int dn;
        rst = 1'b1; start_valid = 1'b0; limit = '0; mode = 1'b0;
        pause = 1'b0; abort = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(start_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_done", int'(done), 0);

        // one-shot limit 3
        start(3, 1'b0);
        chk("os_busy", int'(busy), 1);
        chk("os_ready", int'(start_ready), 0);
`ifndef COUNTER_CTRL_PRESCALE_EN
        chk("os_c0", int'(count), 0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("os_seq", int'(count), i);
            chk("os_notick", int'(tick), 0);
        end
        cyc();
        chk("os_tick", int'(tick), 1);
        chk("os_tick_done", int'(done), 0);
        chk("os_tick_cnt", int'(count), 3);
        cyc();
        chk("os_done", int'(done), 1);
        chk("os_done_tick", int'(tick), 0);
        chk("os_done_ready", int'(start_ready), 1);
        repeat (2) cyc();
        chk("os_hold_cnt", int'(count), 3);
        chk("os_done_once", int'(done), 0);
`endif
        idle_out();

        // periodic limit 2
        start(2, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cyc();
`ifndef COUNTER_CTRL_PRESCALE_EN
            chk("per_seq", int'(count), i % 3);
            chk("per_tick", int'(tick), int'(i % 3 == 0));
`endif
            chk("per_nodone", int'(done), 0);
        end
        idle_out();

        // periodic full-range limit
        ticks = 0;
        start(15, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            if (tick) ticks++;
`ifndef COUNTER_CTRL_PRESCALE_EN
            chk("full_seq", int'(count), i % 16);
`endif
        end
`ifndef COUNTER_CTRL_PRESCALE_EN
        chk("full_ticks", ticks, 2);
`endif
        idle_out();

        // pause in periodic limit 5
        start(5, 1'b1);
        repeat (2) cyc();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pause_busy", int'(busy), 1);
`ifndef COUNTER_CTRL_PRESCALE_EN
            chk("pause_cnt", int'(count), 2);
`endif
        end
        pause = 1'b0;
        cyc();
`ifndef COUNTER_CTRL_PRESCALE_EN
        chk("resume_nostep", int'(count), 2);
`endif
        cyc();
`ifndef COUNTER_CTRL_PRESCALE_EN
        chk("resume_step", int'(count), 3);
`endif
        idle_out();

        // abort then immediate restart
        start(4, 1'b0);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_cnt", int'(count), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(start_ready), 1);
        start(2, 1'b0);
        chk("restart_busy", int'(busy), 1);
        repeat (6) cyc();
        idle_out();

        // start ignored while running, then pause and abort together
        start(3, 1'b1);
        cyc();
        start_valid = 1'b1; limit = 4'd0; mode = 1'b0;
        repeat (3) cyc();
        start_valid = 1'b0;
        repeat (6) cyc();
        pause = 1'b1; abort = 1'b1;
        cyc();
        pause = 1'b0; abort = 1'b0;
        chk("pa_busy", int'(busy), 0);
        cyc();

        // periodic limit 0: tick on every step
        start(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
`ifndef COUNTER_CTRL_PRESCALE_EN
            chk("lim0_tick", int'(tick), 1);
`endif
        end
        idle_out();

        // one-shot limit 0
        start(0, 1'b0);
        repeat (10) cyc();

        // reset mid-sequence
        start(3, 1'b1);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_cnt", int'(count), 0);
        chk("midrst_ready", int'(start_ready), 1);
        chk("midrst_tick", int'(tick), 0);
        cyc();

        // abort during DONE (RUN in prescaled build)
        start(1, 1'b0);
        repeat (2) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("adone_done", int'(done), 0);
        chk("adone_cnt", int'(count), 0);
        cyc();

`ifdef COUNTER_CTRL_PRESCALE_EN
        // prescaled one-shot limit 1
        first1 = -1;
        dn = -1;
        start(1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (count == 4'd1 && first1 < 0) first1 = i;
            if (done) dn = i;
        end
        chk("pre_first_step", first1, 4);
        chk("pre_done_cycle", dn, 9);
`else
        first1 = 0;
        dn = 0;
`endif
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
